// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that lets NUM_REQ requesters share a
// single DATA_W-bit adder. Exactly one requester wins each accept-enabled
// cycle. Its operand pair goes through a grant mux into the adder, and the
// sum is captured in a one-entry result register with valid/ready handshake.
module adder_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 3
) (
    input  logic                                               i_clk,
    input  logic                                               i_rst_n,
    input  logic [NUM_REQ-1:0]                                 i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]                          i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0]                          i_req_b,
    output logic [NUM_REQ-1:0]                                 o_req_ready,
    output logic                                               o_rsp_valid,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   o_rsp_id,
    output logic [DATA_W-1:0]                                  o_rsp_sum,
    output logic                                               o_rsp_cout,
    input  logic                                               i_rsp_ready
);

    localparam int          ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ_U = NUM_REQ;

    // Wraps an index in [0, 2*NUM_REQ) back into [0, NUM_REQ).
    function automatic int unsigned wrap_idx(input int unsigned v);
        return (v >= NREQ_U) ? (v - NREQ_U) : v;
    endfunction

    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
    logic [DATA_W-1:0] rsp_sum_q,   rsp_sum_d;
    logic              rsp_cout_q,  rsp_cout_d;

    logic              grant_found;
    int unsigned       grant_int;
    logic              accept_en;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic [DATA_W:0]   sum_full;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_int   = 0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (!grant_found && i_req_valid[wrap_idx(32'(rr_ptr_q) + i)]) begin
                grant_found = 1'b1;
                grant_int   = wrap_idx(32'(rr_ptr_q) + i);
            end
        end
    end

    // Grant is suppressed in reset and whenever the result register cannot take a new sum.
    always_comb begin
        accept_en   = i_rst_n && (!rsp_valid_q || i_rsp_ready) && grant_found;
        o_req_ready = '0;
        if (accept_en) begin
            o_req_ready[grant_int] = 1'b1;
        end
    end

    // Grant mux feeding the single shared adder.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            if (k == grant_int) begin
                a_sel = i_req_a[k*DATA_W +: DATA_W];
                b_sel = i_req_b[k*DATA_W +: DATA_W];
            end
        end
        sum_full = {1'b0, a_sel} + {1'b0, b_sel};
    end

    // Next-state for the result register and round-robin pointer.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept_en) begin
            // A transfer reloads the register even while the old result drains: no bubble.
            rsp_valid_d = 1'b1;
            rsp_id_d    = ID_W'(grant_int);
            rsp_sum_d   = sum_full[DATA_W-1:0];
            rsp_cout_d  = sum_full[DATA_W];
            rr_ptr_d    = ID_W'(wrap_idx(grant_int + 1));
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_sum   = rsp_sum_q;
    assign o_rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: the driver pushes the expected result
// for every grant it predicts; an independent monitor pops and compares on
// each delivered response.
module tb_adder_arbiter;

    localparam int DW = 32;
    localparam int NR = 3;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_sum;
    logic            rsp_cout;
    logic            rsp_ready;

    logic [DW-1:0]   nxt_a [NR];
    logic [DW-1:0]   nxt_b [NR];
    logic [34:0]     exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    adder_arbiter #(.DATA_W(DW), .NUM_REQ(NR)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout),
        .i_rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, check the grant at the falling edge.
    task automatic step(input logic [2:0] v, input logic rdy, input logic [2:0] exp_g, input string name);
        logic [32:0] s;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            req_a[k*DW +: DW] = nxt_a[k];
            req_b[k*DW +: DW] = nxt_b[k];
        end
        req_valid = v;
        rsp_ready = rdy;
        @(negedge clk);
        check({name, "_grant"}, 64'(req_ready), 64'(exp_g));
        for (int k = 0; k < NR; k++) begin
            if (exp_g[k]) begin
                s = {1'b0, nxt_a[k]} + {1'b0, nxt_b[k]};
                exp_q.push_back({2'(k), s});
            end
        end
    endtask

    task automatic chk_out(input logic v, input logic [1:0] id, input logic c,
                           input logic [31:0] sum, input string name);
        check({name, "_valid"}, 64'(rsp_valid), 64'(v));
        check({name, "_id"},    64'(rsp_id),    64'(id));
        check({name, "_cout"},  64'(rsp_cout),  64'(c));
        check({name, "_sum"},   64'(rsp_sum),   64'(sum));
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 3'b100;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({name, "_ready_in_reset"}, 64'(req_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out(1'b0, 2'd0, 1'b0, 32'h0, name);
        check({name, "_ready_in_reset2"}, 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    // Monitor: every delivered response must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got id=%0d sum=0x%0h with nothing expected", rsp_id, rsp_sum);
                end else begin
                    check("sb_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < NR; k++) begin
            nxt_a[k] = '0;
            nxt_b[k] = '0;
        end

        do_reset("reset");

        // Single request.
        nxt_a[0] = 32'h0000_0004; nxt_b[0] = 32'h0000_1000;
        step(3'b001, 1'b1, 3'b001, "single");
        step(3'b000, 1'b1, 3'b000, "single_rsp");
        chk_out(1'b1, 2'd0, 1'b0, 32'h0000_1004, "single_out");

        // Overflow; rr_ptr is 1 but the lone requester 0 still wins.
        nxt_a[0] = 32'hFFFF_FFFF; nxt_b[0] = 32'h0000_0002;
        step(3'b001, 1'b1, 3'b001, "ovf");
        step(3'b000, 1'b1, 3'b000, "ovf_rsp");
        chk_out(1'b1, 2'd0, 1'b1, 32'h0000_0001, "ovf_out");
        step(3'b000, 1'b1, 3'b000, "ovf_idle");
        check("ovf_valid_clear", 64'(rsp_valid), 64'd0);

        // Round-robin from reset, six back-to-back results.
        do_reset("reset_rr");
        nxt_a[0] = 32'h0000_0100; nxt_b[0] = 32'h0000_0001;
        nxt_a[1] = 32'h0000_0200; nxt_b[1] = 32'h0000_0002;
        nxt_a[2] = 32'hFFFF_FFF0; nxt_b[2] = 32'h0000_0020;
        step(3'b111, 1'b1, 3'b001, "rr0");
        step(3'b111, 1'b1, 3'b010, "rr1");
        chk_out(1'b1, 2'd0, 1'b0, 32'h0000_0101, "rr1_out");
        step(3'b111, 1'b1, 3'b100, "rr2");
        chk_out(1'b1, 2'd1, 1'b0, 32'h0000_0202, "rr2_out");
        step(3'b111, 1'b1, 3'b001, "rr3");
        chk_out(1'b1, 2'd2, 1'b1, 32'h0000_0010, "rr3_out");
        step(3'b111, 1'b1, 3'b010, "rr4");
        check("rr4_valid", 64'(rsp_valid), 64'd1);
        step(3'b111, 1'b1, 3'b100, "rr5");
        check("rr5_valid", 64'(rsp_valid), 64'd1);
        step(3'b000, 1'b1, 3'b000, "rr_drain");
        chk_out(1'b1, 2'd2, 1'b1, 32'h0000_0010, "rr_drain_out");

        // Back-pressure: pending req0 result, req1/req2 waiting for 4 cycles.
        nxt_a[0] = 32'h1234_0000; nxt_b[0] = 32'h0000_5678;
        nxt_a[1] = 32'h8000_0000; nxt_b[1] = 32'h8000_0001;
        nxt_a[2] = 32'h0000_0007; nxt_b[2] = 32'h0000_0009;
        step(3'b001, 1'b1, 3'b001, "bp_load");
        for (int i = 0; i < 4; i++) begin
            step(3'b110, 1'b0, 3'b000, "bp_hold");
            chk_out(1'b1, 2'd0, 1'b0, 32'h1234_5678, "bp_hold_out");
        end
        step(3'b110, 1'b1, 3'b010, "bp_release");
        step(3'b100, 1'b1, 3'b100, "bp_req2");
        chk_out(1'b1, 2'd1, 1'b1, 32'h0000_0001, "bp_req1_out");
        step(3'b000, 1'b1, 3'b000, "bp_drain");
        chk_out(1'b1, 2'd2, 1'b0, 32'h0000_0010, "bp_req2_out");

        // Reset while a result is pending.
        nxt_a[0] = 32'h0000_0011; nxt_b[0] = 32'h0000_0022;
        step(3'b001, 1'b0, 3'b001, "rst_mid_load");
        do_reset("rst_mid");
        nxt_a[2] = 32'h0000_0040; nxt_b[2] = 32'h0000_0003;
        step(3'b100, 1'b1, 3'b100, "rst_mid_req2");
        step(3'b000, 1'b1, 3'b000, "rst_mid_rsp");
        chk_out(1'b1, 2'd2, 1'b0, 32'h0000_0043, "rst_mid_out");

        // Fairness: req0 stays valid while req1 (and once req2) pulse in.
        nxt_a[0] = 32'h0000_0001; nxt_b[0] = 32'h0000_0001;
        nxt_a[1] = 32'h0000_0010; nxt_b[1] = 32'h0000_0010;
        nxt_a[2] = 32'h0000_0100; nxt_b[2] = 32'h0000_0100;
        step(3'b001, 1'b1, 3'b001, "fair0");
        step(3'b011, 1'b1, 3'b010, "fair1");
        step(3'b001, 1'b1, 3'b001, "fair2");
        step(3'b001, 1'b1, 3'b001, "fair3");
        step(3'b111, 1'b1, 3'b010, "fair4");
        step(3'b101, 1'b1, 3'b100, "fair5");
        step(3'b011, 1'b1, 3'b001, "fair6");
        step(3'b011, 1'b1, 3'b010, "fair7");
        step(3'b000, 1'b1, 3'b000, "fair_drain");
        step(3'b000, 1'b1, 3'b000, "fair_idle");
        check("fair_valid_clear", 64'(rsp_valid), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
